// File: rtl/register_window_addr_unit.sv
// rtl/register_window_addr_unit.sv - windowed register file address unit with CWP management.
// Optional macro WINDOW_INVALID_CHECK_EN enables WIM-based overflow/underflow trapping.
module register_window_addr_unit #(
  parameter int NWINDOWS = 8,
  localparam int PHYS_W = ($clog2(8 + 16 * NWINDOWS) > 0) ? $clog2(8 + 16 * NWINDOWS) : 1,
  localparam int CWP_W  = ($clog2(NWINDOWS) > 0) ? $clog2(NWINDOWS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [4:0]        IR_RS1,
  input  logic [4:0]        IR_RS2,
  input  logic [4:0]        IR_RD,
  input  logic [1:0]        MUX_RFA,
  input  logic              MUX_RFB,
  input  logic              Save,
  input  logic              Restore,
  input  logic              CWP_Load,
  input  logic [CWP_W-1:0]  CWP_In,
  input  logic [NWINDOWS-1:0] WIM,
  output logic [PHYS_W-1:0] Register_A_Sel,
  output logic [PHYS_W-1:0] Register_B_Sel,
  output logic [CWP_W-1:0]  CWP,
  output logic              Window_Overflow,
  output logic              Window_Underflow,
  output logic              Op_Error
);

  localparam logic [CWP_W:0]    NWIN_C  = (CWP_W + 1)'(NWINDOWS);
  localparam logic [CWP_W-1:0]  CWP_MAX = CWP_W'(NWINDOWS - 1);
  localparam logic [PHYS_W:0]   SPAN    = (PHYS_W + 1)'(16 * NWINDOWS);
  localparam logic [PHYS_W:0]   EIGHT   = (PHYS_W + 1)'(8);

  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic [PHYS_W-1:0] a_sel_q, a_sel_d;
  logic [PHYS_W-1:0] b_sel_q, b_sel_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              err_q, err_d;
  logic [CWP_W-1:0]  cwp_dec;
  logic [CWP_W-1:0]  cwp_inc;
  logic              load_ok;

  // Windowed registers: offset within the circular 16*NWINDOWS block, so the
  // ins (r24..r31) of window w land on the outs (r8..r15) of window w+1.
  function automatic logic [PHYS_W-1:0] map_reg(input logic [4:0] r, input logic [CWP_W-1:0] w);
    logic [PHYS_W:0] off;
    off = {{(PHYS_W - 3 - CWP_W){1'b0}}, w, 4'b0000} + {{(PHYS_W - 4){1'b0}}, r} - EIGHT;
    if (off >= SPAN) off = off - SPAN;
    if (r < 5'd8) map_reg = {{(PHYS_W - 5){1'b0}}, r};
    else          map_reg = PHYS_W'(off + EIGHT);
  endfunction

  assign cwp_dec = (cwp_q == '0)     ? CWP_MAX : cwp_q - 1'b1;
  assign cwp_inc = (cwp_q == CWP_MAX) ? '0     : cwp_q + 1'b1;
  assign load_ok = ({1'b0, CWP_In} < NWIN_C);

`ifndef WINDOW_INVALID_CHECK_EN
  logic unused_wim;
  assign unused_wim = ^WIM;
`endif

  always_comb begin
    cwp_d = cwp_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    err_d = 1'b0;
    if (CWP_Load) begin
      if (load_ok) cwp_d = CWP_In;
      else         err_d = 1'b1;
    end else if (Save && Restore) begin
      err_d = 1'b1;
    end else if (Save) begin
`ifdef WINDOW_INVALID_CHECK_EN
      if (WIM[cwp_dec]) ovf_d = 1'b1;
      else              cwp_d = cwp_dec;
`else
      cwp_d = cwp_dec;
`endif
    end else if (Restore) begin
`ifdef WINDOW_INVALID_CHECK_EN
      if (WIM[cwp_inc]) unf_d = 1'b1;
      else              cwp_d = cwp_inc;
`else
      cwp_d = cwp_inc;
`endif
    end
  end

  // Selects are mapped with the pre-edge CWP; a CWP change affects the next cycle.
  always_comb begin
    a_sel_d = a_sel_q;
    case (MUX_RFA)
      2'b00:   a_sel_d = map_reg(IR_RS1, cwp_q);
      2'b01:   a_sel_d = '0;
      2'b10:   a_sel_d = map_reg(IR_RD, cwp_q);
      default: a_sel_d = a_sel_q;
    endcase
    b_sel_d = MUX_RFB ? map_reg(IR_RD, cwp_q) : map_reg(IR_RS2, cwp_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cwp_q   <= '0;
      a_sel_q <= '0;
      b_sel_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cwp_q   <= cwp_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  assign CWP              = cwp_q;
  assign Register_A_Sel   = a_sel_q;
  assign Register_B_Sel   = b_sel_q;
  assign Window_Overflow  = ovf_q;
  assign Window_Underflow = unf_q;
  assign Op_Error         = err_q;

endmodule

// File: doc/register_window_addr_unit.md
REGISTER_WINDOW_ADDR_UNIT -- requirements
Module: register_window_addr_unit

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8: number of register windows; legal range 2..32.
REQ-002 SHALL have localparams PHYS_W = clog2(8+16*NWINDOWS) and CWP_W = clog2(NWINDOWS), each at least 1.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports IR_RS1, IR_RS2, IR_RD, input, 5 bits each: architectural register fields.
REQ-006 SHALL have port MUX_RFA, input, 2 bits: port-A source; 00 RS1, 01 r0, 10 RD, 11 hold.
REQ-007 SHALL have port MUX_RFB, input, 1 bit: port-B source; 0 RS2, 1 RD.
REQ-008 SHALL have ports Save and Restore, input, 1 bit each: window decrement and window increment requests.
REQ-009 SHALL have port CWP_Load, input, 1 bit, with CWP_In, input, CWP_W bits: direct CWP write.
REQ-010 SHALL have port WIM, input, NWINDOWS bits: window invalid mask.
REQ-011 SHALL have ports Register_A_Sel and Register_B_Sel, output, PHYS_W bits: registered physical register indices.
REQ-012 SHALL have port CWP, output, CWP_W bits: current window pointer.
REQ-013 SHALL have ports Window_Overflow, Window_Underflow and Op_Error, output, 1 bit each: single-cycle pulses.

Function
REQ-014 SHALL map architectural r0..r7 to physical index r (globals, window-independent).
REQ-015 SHALL map r8..r31 to physical index 8 + ((CWP*16 + r - 8) mod (16*NWINDOWS)), so the ins of window w alias the outs of window w+1 mod NWINDOWS.
REQ-016 SHALL register the Register_A_Sel and Register_B_Sel updates one Clk after the selects and fields are applied, using the CWP value held before that edge.
REQ-017 SHALL update Register_A_Sel to the mapped RS1, 0 or mapped RD for MUX_RFA 00, 01 or 10, and leave it unchanged for MUX_RFA 11.
REQ-018 SHALL update Register_B_Sel to the mapped RS2 or mapped RD according to MUX_RFB.
REQ-019 SHALL, on Save alone, compute target = (CWP-1) mod NWINDOWS; if WIM[target] is 1, keep CWP and pulse Window_Overflow, otherwise load CWP with target.
REQ-020 SHALL, on Restore alone, compute target = (CWP+1) mod NWINDOWS; if WIM[target] is 1, keep CWP and pulse Window_Underflow, otherwise load CWP with target.
REQ-021 SHALL wrap the window pointer: Save at CWP=0 targets NWINDOWS-1, and Restore at CWP=NWINDOWS-1 targets 0.
REQ-022 SHALL give CWP_Load priority over Save and Restore: CWP <= CWP_In when CWP_In < NWINDOWS; otherwise CWP is unchanged and Op_Error pulses.
REQ-023 SHALL treat Save and Restore asserted together without CWP_Load as a no-op that pulses Op_Error.
REQ-024 SHALL apply a new CWP to address mapping from the cycle after the update edge.
REQ-025 SHALL assert the pulse outputs for exactly one cycle, registered, on the edge that evaluates the request.

Reset
REQ-026 SHALL, while Reset_n is 0, force CWP, Register_A_Sel, Register_B_Sel, Window_Overflow, Window_Underflow and Op_Error to 0 immediately, independent of Clk.
REQ-027 SHALL discard any Save, Restore or CWP_Load pending when reset asserts, and resume normal operation on the first rising Clk edge after Reset_n returns to 1.

Configuration
REQ-028 SHALL, with macro WINDOW_INVALID_CHECK_EN defined, implement the WIM checks and pulses of REQ-019 and REQ-020.
REQ-029 SHALL, without WINDOW_INVALID_CHECK_EN, ignore WIM: Save and Restore always move CWP, and Window_Overflow and Window_Underflow are tied 0.

Verification (NWINDOWS=8, WINDOW_INVALID_CHECK_EN defined unless noted)
REQ-030 SHALL cover: after reset, MUX_RFA=00 with IR_RS1=9 -> Register_A_Sel=9 next cycle; MUX_RFA=01 -> 0; MUX_RFA=11 -> previous value held.
REQ-031 SHALL cover: CWP=0, WIM=0, Save -> CWP=7; then IR_RS1=24 -> Register_A_Sel=8+((7*16+16) mod 128)=8, equal to the outs r8 of window 0.
REQ-032 SHALL cover: CWP=0, WIM=8'h80, Save -> CWP stays 0 and Window_Overflow is high for exactly 1 cycle; the same stimulus without the macro -> CWP=7 and no pulse.
REQ-033 SHALL cover: CWP_Load with CWP_In=3 and Save together -> CWP=3 with no pulse; Save and Restore together -> Op_Error pulse and CWP unchanged.
REQ-034 SHALL cover: NWINDOWS=6 with CWP_In=7 -> Op_Error pulse and CWP unchanged; Restore at CWP=5 -> CWP=0.
REQ-035 SHALL cover: Reset_n dropped mid-cycle between edges at CWP=5 -> CWP and all outputs read 0 before the next Clk edge.
